// File: rtl/qc_ldpc_pkg.sv
// Shared types and helpers for the QC-LDPC datapath blocks.
// Holds the delay-line token layout and the degree-counter width helper.
package qc_ldpc_pkg;

    localparam int MAXZ_DEF = 16;
    // Row tags are zero-extended into the token; ROW_W must not exceed this.
    localparam int TOKEN_ROW_W = 16;

    typedef struct packed {
        logic                   valid;
        logic                   last;
        logic [TOKEN_ROW_W-1:0] row;
    } token_t;

    function automatic int deg_w(input int max_deg);
        return $clog2(max_deg + 1);
    endfunction

endpackage

// File: rtl/qc_token_delay.sv
// Fixed-depth shift register of beat tokens.
// Tracks accepted beats alongside the shifter pipeline.
module qc_token_delay
    import qc_ldpc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   CLK,
    input  logic   rst_n,
    input  token_t din,
    output token_t dout
);

    token_t stage [DEPTH];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/qc_syndrome_accumulator.sv
// Per-row XOR accumulator of rotated sub-blocks behind the circular shifter.
// Results leave through a 2-entry FIFO guarded by a credit on last beats.
module qc_syndrome_accumulator
    import qc_ldpc_pkg::*;
#(
    parameter int MAXZ          = MAXZ_DEF,
    parameter int SHIFT_LATENCY = 4,
    parameter int MAX_DEG       = 8,
    parameter int ROW_W         = 8,
    localparam int DEG_W        = deg_w(MAX_DEG)
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [ROW_W-1:0] in_row,
    input  logic [MAXZ-1:0]  sh_data,
    output logic             syn_valid,
    input  logic             syn_ready,
    output logic [MAXZ-1:0]  syn_data,
    output logic             syn_zero,
    output logic [ROW_W-1:0] syn_row,
    output logic [DEG_W-1:0] syn_deg,
    output logic             syn_err
);

    localparam logic [DEG_W-1:0] DEG_MAX = DEG_W'(MAX_DEG);

    typedef struct packed {
        logic [MAXZ-1:0]  data;
        logic             zero;
        logic [ROW_W-1:0] row;
        logic [DEG_W-1:0] deg;
        logic             err;
    } result_t;

    token_t tok_in;
    token_t tok_out;

    logic             accept;
    logic             exit_tok;
    logic             exit_last;
    logic             push;
    logic             pop;

    logic [MAXZ-1:0]  acc;
    logic [MAXZ-1:0]  acc_nxt;
    logic [DEG_W-1:0] deg;
    logic [DEG_W-1:0] deg_nxt;
    logic             err;
    logic             err_nxt;

    result_t          mem [2];
    result_t          res_new;
    result_t          head;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;
    logic [1:0]       lasts;

    assign accept = in_valid && in_ready;

    always_comb begin
        tok_in       = '0;
        tok_in.valid = accept;
        tok_in.last  = in_last;
        tok_in.row   = TOKEN_ROW_W'(in_row);
    end

    qc_token_delay #(
        .DEPTH (SHIFT_LATENCY)
    ) u_delay (
        .CLK   (CLK),
        .rst_n (rst_n),
        .din   (tok_in),
        .dout  (tok_out)
    );

    assign exit_tok  = tok_out.valid;
    assign exit_last = tok_out.valid && tok_out.last;
    assign push      = exit_last;
    assign pop       = syn_valid && syn_ready;

    assign acc_nxt = acc ^ sh_data;
    assign deg_nxt = (deg == DEG_MAX) ? DEG_MAX : deg + 1'b1;
    assign err_nxt = err | (deg == DEG_MAX);

    always_comb begin
        res_new      = '0;
        res_new.data = acc_nxt;
        res_new.zero = (acc_nxt == '0);
        res_new.row  = ROW_W'(tok_out.row);
        res_new.deg  = deg_nxt;
        res_new.err  = err_nxt;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            deg <= '0;
            err <= 1'b0;
        end else if (exit_last) begin
            acc <= '0;
            deg <= '0;
            err <= 1'b0;
        end else if (exit_tok) begin
            acc <= acc_nxt;
            deg <= deg_nxt;
            err <= err_nxt;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res_new;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Last beats in flight already own a FIFO slot.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lasts <= '0;
        end else begin
            unique case ({accept && in_last, exit_last})
                2'b10:   lasts <= lasts + 2'd1;
                2'b01:   lasts <= lasts - 2'd1;
                default: lasts <= lasts;
            endcase
        end
    end

    assign in_ready = ({1'b0, fifo_count} + {1'b0, lasts}) < 3'd2;

    assign head      = mem[rd_ptr];
    assign syn_valid = (fifo_count != 2'd0);
    assign syn_data  = syn_valid ? head.data : '0;
    assign syn_zero  = syn_valid && head.zero;
    assign syn_row   = syn_valid ? head.row : '0;
    assign syn_deg   = syn_valid ? head.deg : '0;
    assign syn_err   = syn_valid && head.err;

endmodule

// File: tb/tb_qc_syndrome_accumulator.sv
// Directed bench for qc_syndrome_accumulator.
// A behavioural rotate-right pipeline stands in for the shifter.
module tb_qc_syndrome_accumulator;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [7:0]  in_row;
    logic [15:0] sh_data;
    logic        syn_valid;
    logic        syn_ready;
    logic [15:0] syn_data;
    logic        syn_zero;
    logic [7:0]  syn_row;
    logic [3:0]  syn_deg;
    logic        syn_err;

    logic [15:0] d_in;
    int          s_in;
    logic [15:0] pipe [4];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    qc_syndrome_accumulator #(
        .MAXZ          (16),
        .SHIFT_LATENCY (4),
        .MAX_DEG       (8),
        .ROW_W         (8)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_row    (in_row),
        .sh_data   (sh_data),
        .syn_valid (syn_valid),
        .syn_ready (syn_ready),
        .syn_data  (syn_data),
        .syn_zero  (syn_zero),
        .syn_row   (syn_row),
        .syn_deg   (syn_deg),
        .syn_err   (syn_err)
    );

    function automatic logic [15:0] rotr(input logic [15:0] d, input int s);
        logic [31:0] w;
        w = {d, d} >> s;
        return w[15:0];
    endfunction

    always @(posedge CLK) begin
        pipe[0] <= rotr(d_in, s_in);
        for (int i = 1; i < 4; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign sh_data = pipe[3];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d, input int s,
                        input logic l, input logic [7:0] r);
        int   n;
        logic ok;
        n = 0;
        @(negedge CLK);
        in_valid = 1'b1;
        d_in     = d;
        s_in     = s;
        in_last  = l;
        in_row   = r;
        while (1) begin
            ok = in_ready;
            @(posedge CLK);
            if (ok) break;
            n++;
            if (n > 100) begin
                chk("beat_timeout", 0, 1);
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_syn(input string tag);
        int n;
        n = 0;
        while (!syn_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, syn_valid, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_valid"}, syn_valid, 0);
        chk({tag, "_data"}, syn_data, 0);
        chk({tag, "_zero"}, syn_zero, 0);
        chk({tag, "_row"}, syn_row, 0);
        chk({tag, "_deg"}, syn_deg, 0);
        chk({tag, "_err"}, syn_err, 0);
    endtask

    logic [7:0] rows [3];
    int         got;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_row    = '0;
        d_in      = '0;
        s_in      = 0;
        syn_ready = 1'b1;
        repeat (3) @(negedge CLK);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge CLK);

        // single-beat row, exact latency
        beat(16'hA5A5, 4, 1'b1, 8'd3);
        idle();
        repeat (3) @(negedge CLK);
        chk("t1_early", syn_valid, 0);
        @(negedge CLK);
        chk("t1_valid", syn_valid, 1);
        chk("t1_data", syn_data, 16'h5A5A);
        chk("t1_zero", syn_zero, 0);
        chk("t1_deg", syn_deg, 1);
        chk("t1_row", syn_row, 3);
        chk("t1_err", syn_err, 0);
        @(negedge CLK);
        chk("t1_popped", syn_valid, 0);

        // two identical beats cancel
        beat(16'h0F0F, 7, 1'b0, 8'd4);
        beat(16'h0F0F, 7, 1'b1, 8'd4);
        idle();
        wait_syn("t2_valid");
        chk("t2_data", syn_data, 16'h0000);
        chk("t2_zero", syn_zero, 1);
        chk("t2_deg", syn_deg, 2);
        chk("t2_row", syn_row, 4);
        @(negedge CLK);

        // back-to-back rows
        beat(16'h0001, 1, 1'b1, 8'd1);
        beat(16'h8000, 0, 1'b1, 8'd2);
        idle();
        repeat (3) @(negedge CLK);
        chk("t3_v1", syn_valid, 1);
        chk("t3_d1", syn_data, 16'h8000);
        chk("t3_r1", syn_row, 1);
        @(negedge CLK);
        chk("t3_v2", syn_valid, 1);
        chk("t3_d2", syn_data, 16'h8000);
        chk("t3_r2", syn_row, 2);
        @(negedge CLK);
        chk("t3_empty", syn_valid, 0);

        // backpressure with three single-beat rows
        syn_ready = 1'b0;
        beat(16'h0010, 0, 1'b1, 8'd0);
        beat(16'h0020, 0, 1'b1, 8'd1);
        idle();
        chk("t4_credit", in_ready, 0);
        got = 0;
        fork
            begin
                beat(16'h0040, 0, 1'b1, 8'd2);
                idle();
            end
            begin
                repeat (8) @(negedge CLK);
                chk("t4_held", in_ready, 0);
                chk("t4_full", syn_valid, 1);
                syn_ready = 1'b1;
                for (int n = 0; n < 40 && got < 3; n++) begin
                    if (syn_valid) begin
                        rows[got] = syn_row;
                        got++;
                    end
                    @(negedge CLK);
                end
            end
        join
        chk("t4_count", got, 3);
        chk("t4_row0", rows[0], 0);
        chk("t4_row1", rows[1], 1);
        chk("t4_row2", rows[2], 2);
        repeat (3) @(negedge CLK);
        chk("t4_nodup", syn_valid, 0);

        // degree overflow
        for (int i = 0; i < 9; i++) begin
            beat(16'h0001, 0, (i == 8), 8'd5);
        end
        idle();
        wait_syn("t5_valid");
        chk("t5_deg", syn_deg, 8);
        chk("t5_err", syn_err, 1);
        chk("t5_data", syn_data, 16'h0001);
        @(negedge CLK);
        beat(16'h0003, 0, 1'b1, 8'd6);
        idle();
        wait_syn("t5_next_valid");
        chk("t5_next_err", syn_err, 0);
        chk("t5_next_deg", syn_deg, 1);
        chk("t5_next_data", syn_data, 16'h0003);
        @(negedge CLK);

        // reset with beats in flight
        beat(16'hFFFF, 0, 1'b0, 8'd7);
        beat(16'h1234, 0, 1'b0, 8'd7);
        idle();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6_rst");
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        repeat (6) @(negedge CLK);
        chk("t6_no_stale", syn_valid, 0);
        beat(16'h00F0, 4, 1'b1, 8'd9);
        idle();
        wait_syn("t6_valid");
        chk("t6_data", syn_data, 16'h000F);
        chk("t6_deg", syn_deg, 1);
        chk("t6_row", syn_row, 9);
        chk("t6_err", syn_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
